edff_pipe: RTL and testbench

Parametrised elastic pipeline register: a STAGES-deep chain of enable-gated flops, each with its own valid bit and valid/ready handshake, bubble collapsing and synchronous flush. It replaces hand-chained enable flops wherever RVV datapaths need a retimed, back-pressurable path, such as dispatch-to-lane or lane-to-writeback.

---
 rtl/edff_pipe_pkg.sv | 9 +
 rtl/edff_pipe_stage.sv | 58 +++++
 rtl/edff_pipe.sv | 97 +++++++++
 tb/tb_edff_pipe.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/edff_pipe_pkg.sv
// Shared helpers for the elastic pipeline register.
//   occ_width(stages): bits needed to hold an occupancy count of 0..stages.
package edff_pipe_pkg;

  function automatic int unsigned occ_width(input int unsigned stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/edff_pipe_stage.sv
// One elastic pipeline stage: a valid bit plus an enable-gated payload register.
//   clk, rst      : rising-edge clock, asynchronous active-high reset
//   flush_i       : synchronous flush, clears the valid bit, payload holds
//   src_valid_i   : upstream stage (or pipeline input) holds data
//   src_data_i    : upstream payload
//   dst_ready_i   : downstream stage (or pipeline output) can take data
//   v_o, d_o      : current valid bit and payload
//   v_d_o         : next-state valid bit (feeds the occupancy count)
//   rdy_o         : this stage can load this cycle
module edff_pipe_stage #(
  parameter int unsigned      WIDTH = 32,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             src_valid_i,
  input  logic [WIDTH-1:0] src_data_i,
  input  logic             dst_ready_i,
  output logic             v_o,
  output logic             v_d_o,
  output logic [WIDTH-1:0] d_o,
  output logic             rdy_o
);

  logic             v_q, v_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             en;

  always_comb begin
    // An empty stage always accepts, so bubbles collapse behind a stall.
    rdy_o = !v_q || dst_ready_i;
    en    = rdy_o && src_valid_i && !flush_i;
    d_d   = en ? src_data_i : d_q;
    if (flush_i) begin
      v_d = 1'b0;
    end else if (rdy_o) begin
      v_d = src_valid_i;
    end else begin
      v_d = v_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= 1'b0;
      d_q <= INIT;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  assign v_o   = v_q;
  assign v_d_o = v_d;
  assign d_o   = d_q;

endmodule

// File: rtl/edff_pipe.sv
// Parametrised elastic pipeline register: STAGES chained valid/ready stages with
// bubble collapsing, synchronous flush and a registered occupancy count.
//   clk, rst            : rising-edge clock, asynchronous active-high reset
//   flush               : drop every held entry at the next edge
//   in_valid/in_ready   : upstream handshake, in_data payload
//   out_valid/out_ready : downstream handshake, out_data payload
//   count               : number of valid stages (0..STAGES)
module edff_pipe
  import edff_pipe_pkg::*;
#(
  parameter int unsigned      WIDTH  = 32,
  parameter int unsigned      STAGES = 2,
  parameter logic [WIDTH-1:0] INIT   = '0,
  parameter int unsigned      CNTW   = $clog2(STAGES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNTW-1:0]  count
);

  if (STAGES == 0) begin : g_bad_stages
    $error("edff_pipe: STAGES must be at least 1");
  end
  if (CNTW != occ_width(STAGES)) begin : g_bad_cntw
    $error("edff_pipe: CNTW is derived from STAGES and must not be overridden");
  end

  logic [STAGES-1:0] v_next;
  logic [CNTW-1:0]   count_q, count_d;

  // Each stage's ready looks at the next stage's ready, giving a combinational
  // ready chain from out_ready back to in_ready.
  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic             src_valid, dst_ready, rdy, v, v_d;
    logic [WIDTH-1:0] src_data, d;

    if (i == 0) begin : g_first
      assign src_valid = in_valid;
      assign src_data  = in_data;
    end else begin : g_mid
      assign src_valid = g_stage[i-1].v;
      assign src_data  = g_stage[i-1].d;
    end

    if (i == STAGES - 1) begin : g_last
      assign dst_ready = out_ready;
    end else begin : g_inner
      assign dst_ready = g_stage[i+1].rdy;
    end

    edff_pipe_stage #(
      .WIDTH (WIDTH),
      .INIT  (INIT)
    ) u_stage (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (flush),
      .src_valid_i (src_valid),
      .src_data_i  (src_data),
      .dst_ready_i (dst_ready),
      .v_o         (v),
      .v_d_o       (v_d),
      .d_o         (d),
      .rdy_o       (rdy)
    );

    assign v_next[i] = v_d;
  end

  always_comb begin
    count_d = '0;
    for (int i = 0; i < int'(STAGES); i++) begin
      count_d = count_d + CNTW'(v_next[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign in_ready  = g_stage[0].rdy && !flush;
  assign out_valid = g_stage[STAGES-1].v && !flush;
  assign out_data  = g_stage[STAGES-1].d;
  assign count     = count_q;

endmodule

// File: tb/tb_edff_pipe.sv
// Directed self-checking bench for edff_pipe (WIDTH=8, STAGES=3, INIT=8'hA5).
module tb_edff_pipe;

  localparam int unsigned      W    = 8;
  localparam int unsigned      S    = 3;
  localparam logic [W-1:0]     INIT = 8'hA5;
  localparam int unsigned      CW   = $clog2(S + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [CW-1:0] count;

  int total = 0;
  int bad   = 0;

  edff_pipe #(
    .WIDTH  (W),
    .STAGES (S),
    .INIT   (INIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset state
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'hA5);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    tick();
    rst = 1'b0;
    tick();

    // Streaming: beat k accepted at edge k appears after edge k+2
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      in_data = W'(k);
      #1;
      chk("stream_in_ready", 32'(in_ready), 32'd1);
      tick();
      if (k >= 3) begin
        chk("stream_out_valid", 32'(out_valid), 32'd1);
        chk("stream_out_data", 32'(out_data), 32'(k - 2));
        chk("stream_count", 32'(count), 32'd3);
      end else begin
        chk("stream_fill_valid", 32'(out_valid), 32'd0);
        chk("stream_fill_count", 32'(count), 32'(k));
      end
    end
    in_valid = 1'b0;
    tick();
    chk("drain_data7", 32'(out_data), 32'd7);
    chk("drain_count2", 32'(count), 32'd2);
    tick();
    chk("drain_data8", 32'(out_data), 32'd8);
    chk("drain_count1", 32'(count), 32'd1);
    tick();
    chk("drain_empty_valid", 32'(out_valid), 32'd0);
    chk("drain_empty_count", 32'(count), 32'd0);

    // Back-pressure: three beats fill the stalled pipe, the fourth waits
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h11;
    #1;
    chk("bp_rdy1", 32'(in_ready), 32'd1);
    tick();
    in_data = 8'h12;
    #1;
    chk("bp_rdy2", 32'(in_ready), 32'd1);
    tick();
    in_data = 8'h13;
    #1;
    chk("bp_rdy3", 32'(in_ready), 32'd1);
    tick();
    chk("bp_count3", 32'(count), 32'd3);
    chk("bp_head", 32'(out_data), 32'h11);
    in_data = 8'h14;
    #1;
    chk("bp_rdy4_blocked", 32'(in_ready), 32'd0);
    tick();
    chk("bp_hold_count", 32'(count), 32'd3);
    chk("bp_hold_data", 32'(out_data), 32'h11);
    chk("bp_hold_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    #1;
    chk("bp_release_rdy", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_emit12", 32'(out_data), 32'h12);
    chk("bp_full_count", 32'(count), 32'd3);
    tick();
    chk("bp_emit13", 32'(out_data), 32'h13);
    chk("bp_emit13_valid", 32'(out_valid), 32'd1);
    tick();
    chk("bp_emit14", 32'(out_data), 32'h14);
    chk("bp_emit14_count", 32'(count), 32'd1);
    tick();
    chk("bp_empty_count", 32'(count), 32'd0);

    // Bubble collapse: only the last stage full and stalled
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h21;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("bub_count1", 32'(count), 32'd1);
    chk("bub_head", 32'(out_data), 32'h21);
    in_valid = 1'b1;
    in_data  = 8'h22;
    #1;
    chk("bub_rdy_a", 32'(in_ready), 32'd1);
    tick();
    in_data = 8'h23;
    #1;
    chk("bub_rdy_b", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("bub_count3", 32'(count), 32'd3);
    chk("bub_full_rdy", 32'(in_ready), 32'd0);
    chk("bub_head_kept", 32'(out_data), 32'h21);

    // Flush with count=2: no handshake, everything invalid next cycle
    out_ready = 1'b1;
    tick();
    chk("fl_count2", 32'(count), 32'd2);
    chk("fl_head", 32'(out_data), 32'h22);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h99;
    #1;
    chk("fl_in_ready", 32'(in_ready), 32'd0);
    chk("fl_out_valid", 32'(out_valid), 32'd0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("fl_count0", 32'(count), 32'd0);
    chk("fl_valid0", 32'(out_valid), 32'd0);
    chk("fl_payload_held", 32'(out_data), 32'h22);
    chk("fl_after_rdy", 32'(in_ready), 32'd1);

    // Asynchronous reset with a full pipe
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h31;
    tick();
    in_data = 8'h32;
    tick();
    in_data = 8'h33;
    tick();
    in_valid = 1'b0;
    chk("ar_pre_count", 32'(count), 32'd3);
    chk("ar_pre_valid", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_valid_drop", 32'(out_valid), 32'd0);
    chk("ar_data_init", 32'(out_data), 32'hA5);
    chk("ar_count0", 32'(count), 32'd0);
    #1;
    rst = 1'b0;
    tick();

    // Normal latency after reset release
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h41;
    tick();
    in_data = 8'h42;
    chk("ar_lat1_valid", 32'(out_valid), 32'd0);
    tick();
    in_data = 8'h43;
    chk("ar_lat2_valid", 32'(out_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    chk("ar_lat3_valid", 32'(out_valid), 32'd1);
    chk("ar_lat3_data", 32'(out_data), 32'h41);
    tick();
    chk("ar_next_data", 32'(out_data), 32'h42);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
